// File: rtl/call_stack_ctrl.sv
// Sequencer/arbiter for the hardware return-address stack: grants CALL, RET,
// IRQ-entry and RETI one at a time, drives push/pop, tracks depth and traps errors.
module call_stack_ctrl #(
    parameter int               WIDTH      = 13,
    parameter int               DEPTH      = 3,
    parameter logic [WIDTH-1:0] IRQ_VECTOR = 13'h004,
    parameter logic [WIDTH-1:0] UFL_VECTOR = 13'h000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             call_req,
    input  logic             ret_req,
    input  logic             irq_req,
    input  logic             reti_req,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] target,
    output logic             call_ack,
    output logic             ret_ack,
    output logic             irq_ack,
    output logic             reti_ack,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_d,
    input  logic [WIDTH-1:0] stk_q,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_next,
    output logic             busy,
    output logic [DEPTH:0]   depth,
    output logic             full,
    output logic             empty,
    output logic             in_isr,
    output logic             ovf,
    output logic             ufl,
    input  logic             err_clr
);

    typedef enum logic [1:0] {IDLE, PUSH, POP, RLOAD} state_t;

    localparam int             CAP      = 1 << DEPTH;
    localparam logic [DEPTH:0] CAPACITY = CAP[DEPTH:0];

    state_t           state, state_nx;
    logic [WIDTH-1:0] push_d;     // return address captured at grant
    logic [WIDTH-1:0] jump_pc;    // destination captured at grant
    logic             ret_ufl;    // pending RLOAD came from an empty-stack return
    logic             idle;
    logic             grant_irq, grant_reti, grant_ret, grant_call;
    logic             ovf_set, ufl_set;

    assign full  = (depth == CAPACITY);
    assign empty = (depth == '0);

    // Fixed priority; a busy controller or an active reset grants nothing.
    assign idle       = (state == IDLE) && !reset;
    assign grant_irq  = idle && irq_req && !in_isr;
    assign grant_reti = idle && reti_req && !grant_irq;
    assign grant_ret  = idle && ret_req && !grant_irq && !reti_req;
    assign grant_call = idle && call_req && !grant_irq && !reti_req && !ret_req;

    assign irq_ack  = grant_irq;
    assign reti_ack = grant_reti;
    assign ret_ack  = grant_ret;
    assign call_ack = grant_call;

    assign ovf_set = (state == PUSH) && full;
    assign ufl_set = (grant_ret || grant_reti) && empty;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nx = state;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_d    = '0;
        pc_load  = 1'b0;
        pc_next  = '0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_irq || grant_call)
                    state_nx = PUSH;
                else if (grant_ret || grant_reti)
                    state_nx = empty ? RLOAD : POP;
            end
            PUSH: begin
                busy     = 1'b1;
                stk_push = !full;
                stk_d    = push_d;
                pc_load  = 1'b1;
                pc_next  = jump_pc;
                state_nx = IDLE;
            end
            POP: begin
                busy     = 1'b1;
                stk_pop  = 1'b1;
                state_nx = RLOAD;
            end
            RLOAD: begin
                busy     = 1'b1;
                pc_load  = 1'b1;
                pc_next  = ret_ufl ? UFL_VECTOR : stk_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            depth   <= '0;
            in_isr  <= 1'b0;
            ovf     <= 1'b0;
            ufl     <= 1'b0;
            push_d  <= '0;
            jump_pc <= '0;
            ret_ufl <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_call) begin
                push_d  <= pc_in + WIDTH'(1);
                jump_pc <= target;
            end
            if (grant_irq) begin
                push_d  <= pc_in;
                jump_pc <= IRQ_VECTOR;
                in_isr  <= 1'b1;
            end
            if (grant_reti)
                in_isr <= 1'b0;
            if (grant_ret || grant_reti)
                ret_ufl <= empty;

            if (state == PUSH && !full)
                depth <= depth + 1'b1;
            else if (state == POP)
                depth <= depth - 1'b1;

            // A flag being set in the same cycle beats err_clr.
            if (ovf_set)      ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
            if (ufl_set)      ufl <= 1'b1;
            else if (err_clr) ufl <= 1'b0;
        end
    end

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Self-checking bench for call_stack_ctrl: directed scenarios followed by random
// CALL/RET/IRQ/RETI traffic checked against a transaction-level stack model.
module tb_call_stack_ctrl;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         call_req = 1'b0, ret_req = 1'b0, irq_req = 1'b0, reti_req = 1'b0;
    logic [W-1:0] pc_in = '0, target = '0;
    logic         call_ack, ret_ack, irq_ack, reti_ack;
    logic         stk_push, stk_pop;
    logic [W-1:0] stk_d, stk_q, pc_next;
    logic         pc_load, busy, full, empty, in_isr, ovf, ufl;
    logic [3:0]   depth;
    logic         err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected architectural state
    logic [W-1:0] model[$];
    bit           m_isr, m_ovf, m_ufl;

    // Stack device: contents as actually pushed by the DUT
    logic [W-1:0] mem[$];

    call_stack_ctrl dut (
        .clk(clk), .reset(reset),
        .call_req(call_req), .ret_req(ret_req), .irq_req(irq_req), .reti_req(reti_req),
        .pc_in(pc_in), .target(target),
        .call_ack(call_ack), .ret_ack(ret_ack), .irq_ack(irq_ack), .reti_ack(reti_ack),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_d(stk_d), .stk_q(stk_q),
        .pc_load(pc_load), .pc_next(pc_next), .busy(busy), .depth(depth),
        .full(full), .empty(empty), .in_isr(in_isr), .ovf(ovf), .ufl(ufl),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            mem.delete();
            stk_q <= '0;
        end else begin
            if (stk_push) mem.push_back(stk_d);
            if (stk_pop && mem.size() > 0) stk_q <= mem.pop_back();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},   busy,   0);
        check({tag, "_depth"},  depth,  model.size());
        check({tag, "_full"},   full,   model.size() == 8);
        check({tag, "_empty"},  empty,  model.size() == 0);
        check({tag, "_in_isr"}, in_isr, m_isr);
        check({tag, "_ovf"},    ovf,    m_ovf);
        check({tag, "_ufl"},    ufl,    m_ufl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        {call_req, ret_req, irq_req, reti_req, err_clr} = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model.delete();
        m_isr = 0; m_ovf = 0; m_ufl = 0;
    endtask

    function automatic logic ack_of(input int kind);
        case (kind)
            0:       return call_ack;
            1:       return ret_ack;
            2:       return irq_ack;
            default: return reti_ack;
        endcase
    endfunction

    // kind: 0 CALL, 1 RET, 2 IRQ, 3 RETI
    task automatic do_op(input int kind, input logic [W-1:0] pc, input logic [W-1:0] tgt);
        bit           got;
        bit           was_full;
        logic [W-1:0] exp_ret;
        @(negedge clk);
        pc_in  = pc;
        target = tgt;
        call_req = (kind == 0); ret_req = (kind == 1);
        irq_req  = (kind == 2); reti_req = (kind == 3);
        #1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (ack_of(kind)) got = 1;
            else begin @(negedge clk); #1; end
        end
        check("grant_ack", got, 1);
        check("grant_busy", busy, 0);
        @(negedge clk);
        {call_req, ret_req, irq_req, reti_req} = '0;
        #1;
        if (kind == 0 || kind == 2) begin
            was_full = (model.size() == 8);
            check("push_strobe", stk_push, !was_full);
            check("push_no_pop", stk_pop, 0);
            if (!was_full) check("push_d", stk_d, (kind == 0) ? W'(pc + 1) : pc);
            check("push_pc_load", pc_load, 1);
            check("push_pc_next", pc_next, (kind == 0) ? tgt : 13'h004);
            check("push_busy", busy, 1);
            if (was_full) m_ovf = 1; else model.push_back((kind == 0) ? W'(pc + 1) : pc);
            if (kind == 2) m_isr = 1;
        end else begin
            if (kind == 3) m_isr = 0;
            if (model.size() == 0) begin
                check("ufl_no_pop", stk_pop, 0);
                check("ufl_pc_load", pc_load, 1);
                check("ufl_pc_next", pc_next, 0);
                m_ufl = 1;
            end else begin
                check("pop_strobe", stk_pop, 1);
                check("pop_no_load", pc_load, 0);
                exp_ret = model.pop_back();
                @(negedge clk); #1;
                check("rload_pc_load", pc_load, 1);
                check("rload_pc_next", pc_next, exp_ret);
                check("rload_no_pop", stk_pop, 0);
            end
        end
        @(negedge clk); #1;
        check_idle("after_op");
    endtask

    task automatic do_clear();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ovf = 0; m_ufl = 0;
        #1;
        check("clr_ovf", ovf, 0);
        check("clr_ufl", ufl, 0);
    endtask

    initial begin
        int kind;
        // Reset values
        do_reset();
        #1;
        check("rst_pc_load", pc_load, 0);
        check("rst_pc_next", pc_next, 0);
        check("rst_stk_d",   stk_d,   0);
        check("rst_push",    stk_push, 0);
        check("rst_pop",     stk_pop,  0);
        check("rst_acks",    {call_ack, ret_ack, irq_ack, reti_ack}, 0);
        check_idle("reset");

        // Basic CALL then RET
        do_op(0, 13'h010, 13'h100);
        do_op(1, 13'h000, 13'h000);

        // Simultaneous irq+ret+call: irq first, then ret, then call
        @(negedge clk);
        irq_req = 1; ret_req = 1; call_req = 1;
        pc_in = 13'h050; target = 13'h200;
        #1;
        check("arb_irq_ack",  irq_ack,  1);
        check("arb_ret_ack",  ret_ack,  0);
        check("arb_call_ack", call_ack, 0);
        @(negedge clk);
        irq_req = 0;
        #1;
        check("arb_irq_push", stk_push, 1);
        check("arb_irq_d",    stk_d,    13'h050);
        check("arb_irq_pc",   pc_next,  13'h004);
        check("arb_no_ack_busy", {ret_ack, call_ack}, 0);
        @(negedge clk); #1;
        check("arb_in_isr",   in_isr,   1);
        check("arb_ret_ack2", ret_ack,  1);
        check("arb_call_ack2", call_ack, 0);
        @(negedge clk);
        ret_req = 0;
        #1;
        check("arb_ret_pop", stk_pop, 1);
        @(negedge clk); #1;
        check("arb_ret_pc", pc_next, 13'h050);
        check("arb_ret_load", pc_load, 1);
        @(negedge clk); #1;
        check("arb_call_ack3", call_ack, 1);
        @(negedge clk);
        call_req = 0;
        #1;
        check("arb_call_d",  stk_d,   13'h051);
        check("arb_call_pc", pc_next, 13'h200);
        model.push_back(13'h051);
        m_isr = 1;
        @(negedge clk); #1;
        check_idle("arb_end");

        // Overflow at capacity, then error clear
        do_reset();
        for (int i = 0; i < 8; i++) do_op(0, W'(16 * i), W'(13'h300 + i));
        check("ovf_full", full, 1);
        check("ovf_depth", depth, 8);
        do_op(0, 13'h0A0, 13'h1234);
        check("ovf_flag", ovf, 1);
        do_clear();

        // Underflow from empty
        do_reset();
        do_op(1, 13'h000, 13'h000);
        check("ufl_flag", ufl, 1);
        check("ufl_depth", depth, 0);

        // Reset during POP
        do_reset();
        do_op(2, 13'h077, 13'h000);
        @(negedge clk);
        ret_req = 1;
        #1;
        check("rstpop_ack", ret_ack, 1);
        @(negedge clk);
        ret_req = 0;
        #1;
        check("rstpop_pop", stk_pop, 1);
        reset = 1;
        @(negedge clk); #1;
        check("rstpop_busy",   busy,    0);
        check("rstpop_load",   pc_load, 0);
        check("rstpop_depth",  depth,   0);
        check("rstpop_in_isr", in_isr,  0);
        do_reset();

        // Random traffic
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 3);
            if (kind == 2 && m_isr) kind = 0;
            if ($urandom_range(0, 9) == 0) do_clear();
            do_op(kind, W'($urandom), W'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
